// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC I/O host.
// Contents: FSM state enum, LAD nibble codes (START, CYCTYP, SYNC) and
// response error encodings. No ports.
package lpc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_CYCDIR,
        ST_ADDR,
        ST_WDATA,
        ST_HTAR,
        ST_SYNC,
        ST_RDATA,
        ST_PTAR,
        ST_ABORT,
        ST_RESP
    } lpc_state_t;

    localparam logic [3:0] START_CODE = 4'b0000;
    localparam logic [3:0] CYC_IO_RD  = 4'b0000;
    localparam logic [3:0] CYC_IO_WR  = 4'b0010;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SWAIT = 4'b0101;
    localparam logic [3:0] SYNC_LWAIT = 4'b0110;
    localparam logic [3:0] SYNC_ERR   = 4'b1010;

    localparam logic [3:0] LAD_ONES   = 4'b1111;

    localparam logic [1:0] RSP_OK       = 2'b00;
    localparam logic [1:0] RSP_SYNC_ERR = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT  = 2'b10;

endpackage

// File: rtl/lpc_sync_timer.sv
// SYNC-phase wait tracking for the LPC I/O host.
// Three counters (short wait, long wait, no valid SYNC). Whichever counter
// advances clears the other two; READY/ERR or leaving SYNC clears all.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   en         host is in the SYNC state this clock
//   lad        sampled LAD nibble
//   timeout    this clock's sample brings a counter to its limit
module lpc_sync_timer
    import lpc_pkg::*;
#(
    parameter int NOSYNC_LIMIT     = 4,
    parameter int SHORT_WAIT_LIMIT = 64,
    parameter int LONG_WAIT_LIMIT  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] lad,
    output logic       timeout
);

    localparam int MAX_AB = (NOSYNC_LIMIT > SHORT_WAIT_LIMIT) ? NOSYNC_LIMIT : SHORT_WAIT_LIMIT;
    localparam int MAX_L  = (MAX_AB > LONG_WAIT_LIMIT) ? MAX_AB : LONG_WAIT_LIMIT;
    localparam int CW     = $clog2(MAX_L + 1);

    logic [CW-1:0] s_cnt, l_cnt, n_cnt;
    logic [CW-1:0] s_nx, l_nx, n_nx;

    always_comb begin
        s_nx = '0;
        l_nx = '0;
        n_nx = '0;
        if (en) begin
            case (lad)
                SYNC_READY, SYNC_ERR: ;
                SYNC_SWAIT:           s_nx = s_cnt + 1'b1;
                SYNC_LWAIT:           l_nx = l_cnt + 1'b1;
                default:              n_nx = n_cnt + 1'b1;
            endcase
        end
    end

    // Counters never pass their limit: a timeout leaves SYNC, which clears them.
    assign timeout = en && ((s_nx >= CW'(SHORT_WAIT_LIMIT)) ||
                            (l_nx >= CW'(LONG_WAIT_LIMIT))  ||
                            (n_nx >= CW'(NOSYNC_LIMIT)));

    always_ff @(posedge clk) begin
        if (rst) begin
            s_cnt <= '0;
            l_cnt <= '0;
            n_cnt <= '0;
        end else begin
            s_cnt <= s_nx;
            l_cnt <= l_nx;
            n_cnt <= n_nx;
        end
    end

endmodule

// File: rtl/lpc_io_host.sv
// LPC I/O-cycle initiator (host side). Accepts single-byte I/O read/write
// requests, drives LFRAME#/LAD, collects SYNC and read data, and returns
// one response per request.
// Ports:
//   Mclk, MainReset          clock, synchronous active-high reset
//   ReqValid/ReqReady        request handshake; ReqWrite, ReqAddr, ReqWrData
//   RspValid                 one-clock completion pulse; RspRdData, RspError
//   LFrameN, LadOut, LadOe   LPC bus drive; LadIn sampled LAD
// Build option: define LPC_IO_HOST_ABORT_EN to issue an abort frame
// (LFRAME# low with LAD=1111 for 4 clocks) on SYNC timeout.
module lpc_io_host
    import lpc_pkg::*;
#(
    parameter int NOSYNC_LIMIT     = 4,
    parameter int SHORT_WAIT_LIMIT = 64,
    parameter int LONG_WAIT_LIMIT  = 1024
) (
    input  logic        Mclk,
    input  logic        MainReset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [15:0] ReqAddr,
    input  logic [7:0]  ReqWrData,
    output logic        RspValid,
    output logic [7:0]  RspRdData,
    output logic [1:0]  RspError,
    output logic        LFrameN,
    output logic [3:0]  LadOut,
    output logic        LadOe,
    input  logic [3:0]  LadIn
);

    lpc_state_t state, state_nx;
    logic [2:0]  step;      // clock index within multi-clock states
    logic        wr_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rd_data;
    logic [1:0]  err_q;
    logic        timeout;
    logic        sync_done;

    lpc_sync_timer #(
        .NOSYNC_LIMIT     (NOSYNC_LIMIT),
        .SHORT_WAIT_LIMIT (SHORT_WAIT_LIMIT),
        .LONG_WAIT_LIMIT  (LONG_WAIT_LIMIT)
    ) u_timer (
        .clk     (Mclk),
        .rst     (MainReset),
        .en      (state == ST_SYNC),
        .lad     (LadIn),
        .timeout (timeout)
    );

    assign sync_done = (LadIn == SYNC_READY) || (LadIn == SYNC_ERR);
    assign ReqReady  = (state == ST_IDLE) && !MainReset;
    assign RspValid  = (state == ST_RESP);
    assign RspError  = err_q;
    assign RspRdData = (err_q == RSP_OK && !wr_q) ? rd_data : 8'hFF;

    always_comb begin
        state_nx = state;
        LFrameN  = 1'b1;
        LadOut   = LAD_ONES;
        LadOe    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ReqValid) state_nx = ST_START;
            end
            ST_START: begin
                LFrameN  = 1'b0;
                LadOut   = START_CODE;
                LadOe    = 1'b1;
                state_nx = ST_CYCDIR;
            end
            ST_CYCDIR: begin
                LadOut   = wr_q ? CYC_IO_WR : CYC_IO_RD;
                LadOe    = 1'b1;
                state_nx = ST_ADDR;
            end
            ST_ADDR: begin
                LadOe = 1'b1;
                case (step[1:0])
                    2'd0:    LadOut = addr_q[15:12];
                    2'd1:    LadOut = addr_q[11:8];
                    2'd2:    LadOut = addr_q[7:4];
                    default: LadOut = addr_q[3:0];
                endcase
                if (step[1:0] == 2'd3) state_nx = wr_q ? ST_WDATA : ST_HTAR;
            end
            ST_WDATA: begin
                LadOe  = 1'b1;
                LadOut = step[0] ? wdata_q[7:4] : wdata_q[3:0];
                if (step[0]) state_nx = ST_HTAR;
            end
            ST_HTAR: begin
                // Drive 1111 for one clock, then release the bus.
                LadOe = !step[0];
                if (step[0]) state_nx = ST_SYNC;
            end
            ST_SYNC: begin
                if (sync_done) state_nx = wr_q ? ST_PTAR : ST_RDATA;
                else if (timeout) begin
`ifdef LPC_IO_HOST_ABORT_EN
                    state_nx = ST_ABORT;
`else
                    state_nx = ST_RESP;
`endif
                end
            end
            ST_RDATA: begin
                if (step[0]) state_nx = ST_PTAR;
            end
            ST_PTAR: begin
                if (step[0]) state_nx = ST_RESP;
            end
            ST_ABORT: begin
                // 4 clocks of LFRAME# low, 1 clock frame high still driving, 1 clock released.
                if (step < 3'd4) begin
                    LFrameN = 1'b0;
                    LadOe   = 1'b1;
                end else if (step == 3'd4) begin
                    LadOe   = 1'b1;
                end
                if (step == 3'd5) state_nx = ST_RESP;
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Mclk) begin
        if (MainReset) begin
            state   <= ST_IDLE;
            step    <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_data <= 8'hFF;
            err_q   <= RSP_OK;
        end else begin
            state <= state_nx;
            step  <= (state_nx != state) ? 3'd0 : step + 3'd1;
            if (state == ST_IDLE && ReqValid) begin
                wr_q    <= ReqWrite;
                addr_q  <= ReqAddr;
                wdata_q <= ReqWrData;
                rd_data <= 8'hFF;
                err_q   <= RSP_OK;
            end
            if (state == ST_SYNC) begin
                if (LadIn == SYNC_ERR) err_q <= RSP_SYNC_ERR;
                else if (timeout)      err_q <= RSP_TIMEOUT;
            end
            if (state == ST_RDATA) begin
                if (step[0]) rd_data[7:4] <= LadIn;
                else         rd_data[3:0] <= LadIn;
            end
        end
    end

endmodule

// File: tb/tb_lpc_io_host.sv
// Directed bench for lpc_io_host: a target model drives LadIn from a
// per-transaction nibble script, expected responses go into a scoreboard
// queue at issue and are checked when RspValid appears.
module tb_lpc_io_host;

    logic        Mclk = 1'b0;
    logic        MainReset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [15:0] ReqAddr;
    logic [7:0]  ReqWrData;
    logic        RspValid;
    logic [7:0]  RspRdData;
    logic [1:0]  RspError;
    logic        LFrameN;
    logic [3:0]  LadOut;
    logic        LadOe;
    logic [3:0]  LadIn;

    always #5 Mclk = ~Mclk;

    lpc_io_host dut (
        .Mclk      (Mclk),
        .MainReset (MainReset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqWrite  (ReqWrite),
        .ReqAddr   (ReqAddr),
        .ReqWrData (ReqWrData),
        .RspValid  (RspValid),
        .RspRdData (RspRdData),
        .RspError  (RspError),
        .LFrameN   (LFrameN),
        .LadOut    (LadOut),
        .LadOe     (LadOe),
        .LadIn     (LadIn)
    );

`ifdef LPC_IO_HOST_ABORT_EN
    localparam int ABORT_CLKS = 6;
    localparam int ABORT_LOW  = 4;
`else
    localparam int ABORT_CLKS = 0;
    localparam int ABORT_LOW  = 0;
`endif

    typedef struct {
        logic [7:0] rdata;
        logic [1:0] err;
        int         lat;
        int         frame_low;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] tgt_q[$];
    int         ncmp  = 0;
    int         nfail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        ncmp++;
        assert (got === want) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Host-side bus drive expected in clock k after the handshake (k=1 is START).
    task automatic exp_host(input int k, input logic wr, input logic [15:0] a,
                            input logic [7:0] wd, output logic f, output logic oe,
                            output logic [3:0] o);
        int h;
        h  = wr ? 9 : 7;
        f  = 1'b1;
        oe = 1'b1;
        o  = 4'hF;
        if (k == 1)                 begin f = 1'b0; o = 4'h0; end
        else if (k == 2)            o = wr ? 4'h2 : 4'h0;
        else if (k >= 3 && k <= 6)  o = a[(15 - 4*(k-3)) -: 4];
        else if (wr && k == 7)      o = wd[3:0];
        else if (wr && k == 8)      o = wd[7:4];
        else if (k == h)            o = 4'hF;
        else if (k == h + 1)        oe = 1'b0;
    endtask

    task automatic txn(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                       input logic [7:0] erd, input logic [1:0] eerr, input int elat,
                       input int elow, input string tag);
        int   sync_start, idx, low;
        bit   done;
        logic ef, eoe;
        logic [3:0] eo;
        exp_t e;
        sb.push_back('{erd, eerr, elat, elow});
        chk({tag, ".ready_before"}, 32'(ReqReady), 32'(1'b1));
        ReqValid  = 1'b1;
        ReqWrite  = wr;
        ReqAddr   = a;
        ReqWrData = wd;
        @(negedge Mclk);
        ReqValid  = 1'b0;
        ReqWrite  = ~wr;
        ReqAddr   = 16'($urandom);
        ReqWrData = 8'($urandom);
        sync_start = wr ? 11 : 9;
        done = 1'b0;
        low  = 0;
        for (int k = 1; k <= 1500 && !done; k++) begin
            idx   = k - sync_start;
            LadIn = (idx >= 0 && idx < tgt_q.size()) ? tgt_q[idx] : 4'hF;
            if (k == 1) chk({tag, ".ready_busy"}, 32'(ReqReady), 32'(1'b0));
            if (k < sync_start) begin
                exp_host(k, wr, a, wd, ef, eoe, eo);
                chk({tag, ".lframe"}, 32'(LFrameN), 32'(ef));
                chk({tag, ".lad_oe"}, 32'(LadOe), 32'(eoe));
                if (eoe) chk({tag, ".lad_out"}, 32'(LadOut), 32'(eo));
            end
            if (!LFrameN) low++;
            if (RspValid) begin
                e = sb.pop_front();
                chk({tag, ".rdata"}, 32'(RspRdData), 32'(e.rdata));
                chk({tag, ".err"}, 32'(RspError), 32'(e.err));
                chk({tag, ".latency"}, 32'(k), 32'(e.lat));
                chk({tag, ".frame_low"}, 32'(low), 32'(e.frame_low));
                done = 1'b1;
            end
            @(negedge Mclk);
        end
        LadIn = 4'hF;
        if (!done) begin
            chk({tag, ".rsp_seen"}, 32'(done), 32'(1'b1));
            void'(sb.pop_front());
        end
        chk({tag, ".pulse_end"}, 32'(RspValid), 32'(1'b0));
        chk({tag, ".ready_after"}, 32'(ReqReady), 32'(1'b1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        MainReset = 1'b1;
        ReqValid  = 1'b0;
        ReqWrite  = 1'b0;
        ReqAddr   = '0;
        ReqWrData = '0;
        LadIn     = 4'hF;
        repeat (3) @(negedge Mclk);
        chk("rst.ready", 32'(ReqReady), 32'(1'b0));
        chk("rst.lframe", 32'(LFrameN), 32'(1'b1));
        chk("rst.lad_out", 32'(LadOut), 32'(4'hF));
        chk("rst.lad_oe", 32'(LadOe), 32'(1'b0));
        chk("rst.rsp_valid", 32'(RspValid), 32'(1'b0));
        chk("rst.rdata", 32'(RspRdData), 32'(8'hFF));
        chk("rst.err", 32'(RspError), 32'(2'b00));
        MainReset = 1'b0;
        @(negedge Mclk);

        tgt_q = '{4'h0};
        txn(1'b1, 16'h0601, 8'h5A, 8'hFF, 2'b00, 14, 1, "wr_nowait");

        tgt_q = '{4'h0, 4'h6, 4'h6};
        txn(1'b0, 16'h0603, 8'h00, 8'h66, 2'b00, 14, 1, "rd_nowait");

        tgt_q = '{4'h5, 4'h5, 4'h5, 4'h0, 4'hC, 4'h3};
        txn(1'b0, 16'h1234, 8'h00, 8'h3C, 2'b00, 17, 1, "rd_swait3");

        tgt_q = '{4'hA, 4'hF, 4'hF};
        txn(1'b0, 16'h0080, 8'h00, 8'hFF, 2'b01, 14, 1, "rd_syncerr");

        tgt_q = '{4'h6, 4'h6, 4'hA};
        txn(1'b1, 16'hBEEF, 8'hC3, 8'hFF, 2'b01, 16, 1, "wr_lwait_err");

        tgt_q = '{};
        txn(1'b0, 16'h0060, 8'h00, 8'hFF, 2'b10, 13 + ABORT_CLKS, 1 + ABORT_LOW, "rd_nosync_to");

        // No-sync run broken by a short wait: counters clear on change.
        tgt_q = '{4'hF, 4'hF, 4'hF, 4'h5, 4'hF, 4'hF, 4'hF, 4'h0, 4'h1, 4'h8};
        txn(1'b0, 16'h0F0F, 8'h00, 8'h81, 2'b00, 21, 1, "rd_mixed");

        tgt_q = '{};
        for (int i = 0; i < 63; i++) tgt_q.push_back(4'h5);
        tgt_q.push_back(4'h0); tgt_q.push_back(4'h9); tgt_q.push_back(4'hA);
        txn(1'b0, 16'h0400, 8'h00, 8'hA9, 2'b00, 77, 1, "rd_swait63");

        tgt_q = '{};
        for (int i = 0; i < 64; i++) tgt_q.push_back(4'h5);
        txn(1'b0, 16'h0401, 8'h00, 8'hFF, 2'b10, 73 + ABORT_CLKS, 1 + ABORT_LOW, "rd_swait64_to");

        tgt_q = '{};
        for (int i = 0; i < 1023; i++) tgt_q.push_back(4'h6);
        tgt_q.push_back(4'h0);
        txn(1'b1, 16'h0402, 8'h11, 8'hFF, 2'b00, 1037, 1, "wr_lwait1023");

        // Reset during ADDR: bus released next clock, no response.
        chk("mid.ready_before", 32'(ReqReady), 32'(1'b1));
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 16'h0603;
        @(negedge Mclk);
        ReqValid = 1'b0;
        repeat (2) @(negedge Mclk);
        chk("mid.in_addr_oe", 32'(LadOe), 32'(1'b1));
        MainReset = 1'b1;
        @(negedge Mclk);
        chk("mid.lframe", 32'(LFrameN), 32'(1'b1));
        chk("mid.lad_oe", 32'(LadOe), 32'(1'b0));
        chk("mid.lad_out", 32'(LadOut), 32'(4'hF));
        chk("mid.rsp_valid", 32'(RspValid), 32'(1'b0));
        chk("mid.ready", 32'(ReqReady), 32'(1'b0));
        chk("mid.rdata", 32'(RspRdData), 32'(8'hFF));
        @(negedge Mclk);
        MainReset = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (RspValid) seen++;
            @(negedge Mclk);
        end
        chk("mid.no_rsp", 32'(seen), 32'(0));

        tgt_q = '{4'h0, 4'h7, 4'hE};
        txn(1'b0, 16'h0603, 8'h00, 8'hE7, 2'b00, 14, 1, "rd_after_rst");

        chk("sb.empty", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
